// File: rtl/fp64_square_seq_pkg.sv
// fp64_square_seq_pkg: binary64 field widths, constants and the squaring FSM encoding.
package fp64_square_seq_pkg;
   localparam int EXP_W = 11;
   localparam int FRAC_W = 52;
   localparam int MANT_W = FRAC_W + 1;
   localparam int FP64_BIAS = 1023;
   localparam logic [EXP_W-1:0] EXP_ALL1 = '1;
   localparam logic [63:0] FP64_QNAN = 64'h7FF8_0000_0000_0000;
   localparam logic [63:0] FP64_PINF = 64'h7FF0_0000_0000_0000;
   localparam logic [63:0] FP64_QBIT = 64'h0008_0000_0000_0000;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_UNPACK = 2'd1, S_MUL = 2'd2, S_ROUND = 2'd3} state_t;
endpackage

// File: rtl/fp64_mul_iter.sv
// fp64_mul_iter: iterative unsigned WxW shift-add multiplier, MUL_BITS multiplier bits per step.
module fp64_mul_iter #(
   parameter int MUL_BITS = 1,
   parameter int W = 53
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic             busy,
   output logic             last,
   output logic [2*W+1:0]   product
);
   localparam int NB = 56;
   localparam int M = NB / MUL_BITS;
   localparam int CW = $clog2(M + 1);
   localparam int AW = 2 * W + 2;
   logic [AW-1:0] acc;
   logic [AW-1:0] mcand;
   logic [NB-1:0] mplier;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         mcand <= '0;
         mplier <= '0;
         cnt <= '0;
      end else if (load) begin
         acc <= '0;
         mcand <= AW'(a);
         mplier <= NB'(b);
         cnt <= CW'(M);
      end else if (step && busy) begin
         acc <= acc + mcand * AW'(mplier[MUL_BITS-1:0]);
         mcand <= mcand << MUL_BITS;
         mplier <= mplier >> MUL_BITS;
         cnt <= cnt - CW'(1);
      end
   end
   assign busy = cnt != '0;
   assign last = cnt == CW'(1);
   assign product = acc;
endmodule

// File: rtl/fp64_square_seq.sv
// fp64_square_seq: multi-cycle binary64 squaring y = a*a, RN-even, flush-to-zero on underflow.
module fp64_square_seq
   import fp64_square_seq_pkg::*;
#(
   parameter int MUL_BITS = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] a,
   output logic        ready,
   output logic        done,
   output logic [63:0] y,
   output logic        invalid,
   output logic        inexact,
   output logic        overflow,
   output logic        underflow
);
   state_t state;
   logic [63:0] a_r;
   logic signed [12:0] eo;
   logic signed [12:0] er;
   logic [EXP_W-1:0] ea;
   logic [FRAC_W-1:0] fa;
   logic [FRAC_W-1:0] mant;
   logic [MANT_W-1:0] sum;
   logic [2*MANT_W+1:0] p;
   logic mul_busy, mul_last, hi, g, st, inc, ovf, unf;
   assign ea = a_r[62:52];
   assign fa = a_r[51:0];
   fp64_mul_iter #(.MUL_BITS(MUL_BITS), .W(MANT_W)) u_mul (
      .clk(clk),
      .rst(rst),
      .load(state == S_UNPACK && ea != '0 && ea != EXP_ALL1),
      .step(state == S_MUL),
      .a({1'b1, fa}),
      .b({1'b1, fa}),
      .busy(mul_busy),
      .last(mul_last),
      .product(p)
   );
   // the top two accumulator bits are always zero for a 53x53 product
   always_comb begin
      hi = |p[107:105];
      mant = hi ? p[104:53] : p[103:52];
      g = hi ? p[52] : p[51];
      st = hi ? |p[51:0] : |p[50:0];
      inc = g & (st | mant[0]);
      sum = {1'b0, mant} + MANT_W'(inc);
      er = eo + 13'(hi) + 13'(sum[52]);
      ovf = er >= 13'sd2047;
      unf = er <= 13'sd0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         ready <= 1'b1;
         done <= 1'b0;
         y <= '0;
         {invalid, inexact, overflow, underflow} <= '0;
         a_r <= '0;
         eo <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               a_r <= a;
               y <= '0;
               {invalid, inexact, overflow, underflow} <= '0;
               ready <= 1'b0;
               state <= S_UNPACK;
            end
            S_UNPACK: if (ea == EXP_ALL1) begin
               y <= fa != '0 ? a_r | FP64_QBIT : FP64_PINF;
               invalid <= fa != '0 && !a_r[51];
               {ready, done} <= 2'b11;
               state <= S_IDLE;
            end else if (ea == '0) begin
               underflow <= fa != '0;
               inexact <= fa != '0;
               {ready, done} <= 2'b11;
               state <= S_IDLE;
            end else begin
               eo <= 13'({ea, 1'b0}) - 13'(FP64_BIAS);
               state <= S_MUL;
            end
            S_MUL: if (mul_last || !mul_busy) state <= S_ROUND;
            S_ROUND: begin
               y <= ovf ? FP64_PINF : unf ? 64'd0 : {1'b0, er[10:0], sum[51:0]};
               overflow <= ovf;
               underflow <= unf;
               inexact <= g | st | ovf | unf;
               {ready, done} <= 2'b11;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
